// File: rtl/audiodac_feed_arb.sv
// rtl/audiodac_feed_arb.sv - burst-mode arbiter feeding the audiodac sample FIFO write port
//
// Shares the single audiodac FIFO write port (data/rdy/ack) between two
// streaming sample requesters. A burst only starts on an empty DAC FIFO and
// runs until the FIFO reports full, BURST_MAX words have been written, the
// granted requester stalls for STALL_MAX cycles, or the controller is disabled.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i, prio_i            enable; 0 = round-robin per burst, 1 = req0 priority
//   reqN_data_i/valid_i     requester N sample stream
//   reqN_ready_o            requester N sample taken this cycle (combinational)
//   fifo_o, fifo_rdy_o      sample and request towards audiodac
//   fifo_ack_i              audiodac acknowledge
//   fifo_full_i/empty_i     audiodac FIFO level flags
//   grant_o                 requester owning the current/last burst
//   burst_active_o          high while a burst is in progress
//   underrun_o, clr_i       sticky underrun flag and its clear
module audiodac_feed_arb #(
    parameter int WIDTH     = 16,
    parameter int BURST_MAX = 32,
    parameter int STALL_MAX = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             prio_i,
    input  logic [WIDTH-1:0] req0_data_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req1_data_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    output logic [WIDTH-1:0] fifo_o,
    output logic             fifo_rdy_o,
    input  logic             fifo_ack_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic             grant_o,
    output logic             burst_active_o,
    output logic             underrun_o,
    input  logic             clr_i
);

    localparam int BW = $clog2(BURST_MAX + 1);
    localparam int SW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOAD, PUSH, RELEASE} state_t;

    state_t          state;
    logic            last_grant;
    logic [BW-1:0]   burst_cnt;
    logic [SW-1:0]   stall_cnt;
    logic [SW-1:0]   stall_inc;
    logic            next_grant;
    logic            grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic            start_burst;
    logic            underrun_set;

    // Grant decision for a new burst: with priority, req0 wins whenever valid;
    // round-robin only alternates when both are asking.
    always_comb begin
        next_grant = !req0_valid_i;
        if (!prio_i && req0_valid_i && req1_valid_i) begin
            next_grant = !last_grant;
        end
    end

    assign grant_valid  = grant_o ? req1_valid_i : req0_valid_i;
    assign grant_data   = grant_o ? req1_data_i  : req0_data_i;
    assign start_burst  = en_i && fifo_empty_i && (req0_valid_i || req1_valid_i);
    assign underrun_set = en_i && fifo_empty_i && (state == IDLE) &&
                          !req0_valid_i && !req1_valid_i;
    assign stall_inc    = stall_cnt + SW'(1);

    assign req0_ready_o = (state == LOAD) && !grant_o && req0_valid_i;
    assign req1_ready_o = (state == LOAD) &&  grant_o && req1_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant_o        <= 1'b0;
            burst_active_o <= 1'b0;
            fifo_o         <= '0;
            fifo_rdy_o     <= 1'b0;
            burst_cnt      <= '0;
            stall_cnt      <= '0;
            underrun_o     <= 1'b0;
        end else begin
            // Set wins over a coincident clear.
            if (underrun_set) begin
                underrun_o <= 1'b1;
            end else if (clr_i) begin
                underrun_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_burst) begin
                        grant_o        <= next_grant;
                        last_grant     <= next_grant;
                        burst_cnt      <= '0;
                        stall_cnt      <= '0;
                        burst_active_o <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    // A word offered while ready is visible is always taken,
                    // even if en_i drops in the same cycle; it then completes
                    // and the burst ends from RELEASE.
                    if (grant_valid) begin
                        fifo_o     <= grant_data;
                        fifo_rdy_o <= 1'b1;
                        state      <= PUSH;
                    end else if (!en_i || (stall_inc == SW'(STALL_MAX))) begin
                        burst_active_o <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        stall_cnt <= stall_inc;
                    end
                end
                PUSH: begin
                    if (fifo_ack_i) begin
                        fifo_rdy_o <= 1'b0;
                        if (burst_cnt != BW'(BURST_MAX)) begin
                            burst_cnt <= burst_cnt + BW'(1);
                        end
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Holding here until ack falls makes a long ack one word.
                    if (!fifo_ack_i) begin
                        if (fifo_full_i || (burst_cnt == BW'(BURST_MAX)) || !en_i) begin
                            burst_active_o <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            stall_cnt <= '0;
                            state     <= LOAD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audiodac_feed_arb.sv
// tb/tb_audiodac_feed_arb.sv - self-checking bench for audiodac_feed_arb
module tb_audiodac_feed_arb;

    localparam int W  = 16;
    localparam int BM = 5;
    localparam int SM = 15;

    logic         clk;
    logic         rst_i, en_i, prio_i, clr_i;
    logic [W-1:0] req0_data_i, req1_data_i;
    logic         req0_valid_i, req1_valid_i;
    logic         req0_ready_o, req1_ready_o;
    logic [W-1:0] fifo_o;
    logic         fifo_rdy_o, fifo_ack_i, fifo_full_i, fifo_empty_i;
    logic         grant_o, burst_active_o, underrun_o;

    audiodac_feed_arb #(.WIDTH(W), .BURST_MAX(BM), .STALL_MAX(SM)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .prio_i         (prio_i),
        .req0_data_i    (req0_data_i),
        .req0_valid_i   (req0_valid_i),
        .req0_ready_o   (req0_ready_o),
        .req1_data_i    (req1_data_i),
        .req1_valid_i   (req1_valid_i),
        .req1_ready_o   (req1_ready_o),
        .fifo_o         (fifo_o),
        .fifo_rdy_o     (fifo_rdy_o),
        .fifo_ack_i     (fifo_ack_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_empty_i   (fifo_empty_i),
        .grant_o        (grant_o),
        .burst_active_o (burst_active_o),
        .underrun_o     (underrun_o),
        .clr_i          (clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           tick_n;
    int           d0, d1;            // next sample each requester offers
    logic [W-1:0] exp_q[$];          // samples taken, in order, awaiting ack
    logic [W-1:0] rx_log[$];         // samples written into the DAC FIFO
    int           depth, q_cnt;      // DAC FIFO model
    int           ack_lat, ack_hold, long_ack_word;
    int           wait_cnt, hold_left;
    bit           ack_r;
    bit           last_g;            // requester granted last burst
    int           burst_words, last_burst_words;
    int           r1_cnt, rdy_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_model();
        fifo_ack_i   = ack_r;
        fifo_full_i  = (q_cnt >= depth);
        fifo_empty_i = (q_cnt == 0);
        req0_data_i  = W'(d0);
        req1_data_i  = 16'h8000 | W'(d1 & 16'h7fff);
    endtask

    task automatic drain();
        q_cnt = 0;
        drive_model();
    endtask

    task automatic tick();
        logic pv0, pv1, pprio, r0, r1, pack, prdy, pact, prst, pgnt, eg;
        logic [W-1:0] pfifo;
        #1;
        pv0 = req0_valid_i; pv1 = req1_valid_i; pprio = prio_i;
        r0 = req0_ready_o;  r1 = req1_ready_o;  pack = fifo_ack_i;
        prdy = fifo_rdy_o;  pact = burst_active_o; prst = rst_i;
        pgnt = grant_o;     pfifo = fifo_o;
        @(posedge clk);
        #1;
        tick_n++;
        if (prst) return;

        // Requester side: a sample is consumed when ready was seen at the edge.
        if (r0 || r1) chk("ready_owner", r1, pgnt);
        if (r0) begin exp_q.push_back(W'(d0)); d0++; end
        if (r1) begin exp_q.push_back(16'h8000 | W'(d1 & 16'h7fff)); d1++; r1_cnt++; end

        // Burst start: grant follows the arbitration rule on the sampled valids.
        if (burst_active_o && !pact) begin
            if (pprio)           eg = !pv0;
            else if (pv0 && pv1) eg = !last_g;
            else                 eg = !pv0;
            chk("burst_grant", grant_o, eg);
            last_g = eg;
            burst_words = 0;
        end
        if (!burst_active_o && pact) begin
            last_burst_words = burst_words;
            chk("burst_len_le_max", (burst_words <= BM), 1);
        end

        if (fifo_rdy_o && !prdy) chk("rdy_not_during_ack", pack, 0);
        if (fifo_rdy_o && prdy)  chk("fifo_o_stable", fifo_o, pfifo);
        if (fifo_rdy_o) rdy_cnt++;

        // DAC FIFO model: ack after ack_lat cycles of rdy, hold for ack_hold.
        if (ack_r) begin
            if (hold_left <= 1) ack_r = 1'b0;
            else hold_left--;
        end else if (fifo_rdy_o) begin
            if (wait_cnt >= ack_lat) begin
                ack_r = 1'b1;
                wait_cnt = 0;
                hold_left = (long_ack_word != 0 && burst_words + 1 == long_ack_word) ? 4 : ack_hold;
                rx_log.push_back(fifo_o);
                if (exp_q.size() > 0) chk("word_data", fifo_o, exp_q.pop_front());
                else chk("word_expected", exp_q.size(), 1);
                chk("word_owner", fifo_o[15], grant_o);
                q_cnt++;
                burst_words++;
            end else begin
                wait_cnt++;
            end
        end
        drive_model();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        exp_q.delete(); rx_log.delete();
        ack_r = 1'b0; wait_cnt = 0; hold_left = 0; q_cnt = 0;
        d0 = 1; d1 = 1; last_g = 1'b1; burst_words = 0; last_burst_words = 0;
        drive_model();
        rst_i = 1'b0;
    endtask

    task automatic wait_active(input logic val, input int lim, input string tag);
        for (int i = 0; i < lim && burst_active_o !== val; i++) tick();
        chk(tag, burst_active_o, val);
    endtask

    initial begin
        int n, d0s;
        logic g[6];
        logic [W-1:0] v;
        tick_n = 0; r1_cnt = 0; rdy_cnt = 0;
        en_i = 0; prio_i = 0; clr_i = 0; req0_valid_i = 0; req1_valid_i = 0;
        depth = 4; ack_lat = 0; ack_hold = 1; long_ack_word = 0;
        d0 = 1; d1 = 1; q_cnt = 0; ack_r = 0;
        drive_model();

        // Reset state
        do_reset();
        chk("rst_fifo_o", fifo_o, 0);
        chk("rst_fifo_rdy", fifo_rdy_o, 0);
        chk("rst_grant", grant_o, 0);
        chk("rst_active", burst_active_o, 0);
        chk("rst_underrun", underrun_o, 0);
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);

        // Burst until FIFO full (depth 4), then wait for empty
        en_i = 1; req0_valid_i = 1;
        wait_active(1, 10, "t1_start");
        wait_active(0, 100, "t1_end");
        chk("t1_words", last_burst_words, 4);
        chk("t1_rxcount", rx_log.size(), 4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++) chk("t1_data", rx_log[i], i + 1);
        rdy_cnt = 0;
        repeat (10) tick();
        chk("t1_hold_rdy", rdy_cnt, 0);
        chk("t1_hold_active", burst_active_o, 0);
        drain();
        wait_active(1, 10, "t1_restart");
        for (int i = 0; i < 50 && rx_log.size() < 5; i++) tick();
        v = (rx_log.size() > 4) ? rx_log[4] : 16'hffff;
        chk("t1_next_first", v, 5);
        wait_active(0, 100, "t1_end2");

        // Arbitration: round-robin then fixed priority
        do_reset();
        req0_valid_i = 1; req1_valid_i = 1; prio_i = 0;
        for (int b = 0; b < 6; b++) begin
            wait_active(1, 20, "t2_start");
            g[b] = grant_o;
            wait_active(0, 100, "t2_end");
            if (b == 2) begin prio_i = 1; r1_cnt = 0; end
            drain();
        end
        chk("t2_rr_g0", g[0], 0);
        chk("t2_rr_g1", g[1], 1);
        chk("t2_rr_g2", g[2], 0);
        chk("t2_pr_g0", g[3], 0);
        chk("t2_pr_g1", g[4], 0);
        chk("t2_pr_g2", g[5], 0);
        chk("t2_pr_no_ready1", r1_cnt, 0);

        // BURST_MAX limit with a long ack on word 2
        do_reset();
        req1_valid_i = 0; prio_i = 0; depth = 1000; long_ack_word = 2;
        wait_active(1, 10, "t3_start");
        wait_active(0, 200, "t3_end");
        chk("t3_words", last_burst_words, BM);
        chk("t3_rxcount", rx_log.size(), BM);
        chk("t3_takes", d0, BM + 1);
        long_ack_word = 0;

        // Stall timeout after word 2
        do_reset();
        n = -1;
        wait_active(1, 10, "t4_start");
        for (int i = 0; i < 100; i++) begin
            tick();
            if (req0_valid_i && d0 == 3) req0_valid_i = 0;
            if (burst_words == 2 && !ack_r) begin n = tick_n; break; end
        end
        chk("t4_found", burst_words, 2);
        for (int i = 0; i < 40 && burst_active_o; i++) tick();
        chk("t4_stall_len", tick_n - n, SM + 1);
        chk("t4_stall_words", last_burst_words, 2);

        // Valid returns in LOAD cycle 10: burst resumes
        drain();
        req0_valid_i = 1;
        d0s = d0;
        wait_active(1, 10, "t4b_start");
        for (int i = 0; i < 100; i++) begin
            tick();
            if (req0_valid_i && d0 == d0s + 2) req0_valid_i = 0;
            if (burst_words == 2 && !ack_r) begin n = tick_n; break; end
        end
        while (tick_n < n + 10) tick();
        req0_valid_i = 1;
        for (int i = 0; i < 5 && !fifo_rdy_o; i++) tick();
        chk("t4b_resume_rdy", fifo_rdy_o, 1);
        chk("t4b_resume_time", tick_n - n, 11);
        wait_active(0, 200, "t4b_end");
        chk("t4b_words", last_burst_words, BM);

        // Underrun flag
        do_reset();
        req0_valid_i = 0; req1_valid_i = 0; en_i = 1;
        tick();
        chk("t5_set", underrun_o, 1);
        en_i = 0; clr_i = 1;
        tick();
        clr_i = 0;
        chk("t5_clr", underrun_o, 0);
        en_i = 1; clr_i = 1;
        tick();
        clr_i = 0; en_i = 0;
        chk("t5_set_wins", underrun_o, 1);
        tick();
        chk("t5_sticky", underrun_o, 1);

        // Reset in the middle of PUSH
        do_reset();
        en_i = 1; req0_valid_i = 1; req1_valid_i = 1; prio_i = 0; ack_lat = 1000;
        for (int i = 0; i < 20 && !fifo_rdy_o; i++) tick();
        chk("t6_in_push", fifo_rdy_o, 1);
        chk("t6_first_grant", grant_o, 0);
        rst_i = 1;
        tick();
        chk("t6_rst_rdy", fifo_rdy_o, 0);
        chk("t6_rst_active", burst_active_o, 0);
        chk("t6_rst_grant", grant_o, 0);
        ack_lat = 0;
        do_reset();
        wait_active(1, 10, "t6_restart");
        chk("t6_after_rst_grant", grant_o, 0);
        wait_active(0, 200, "t6_end");

        // Randomized traffic against the scoreboard
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            depth    = $urandom_range(2, 8);
            ack_lat  = $urandom_range(0, 3);
            ack_hold = $urandom_range(1, 3);
            prio_i   = 1'($urandom_range(0, 1));
            drive_model();
            for (int c = 0; c < 300; c++) begin
                req0_valid_i = ($urandom_range(0, 3) != 0);
                req1_valid_i = ($urandom_range(0, 3) != 0);
                en_i         = ($urandom_range(0, 15) != 0);
                if (!burst_active_o && $urandom_range(0, 3) == 0) drain();
                tick();
            end
        end
        req0_valid_i = 0; req1_valid_i = 0; en_i = 1;
        for (int i = 0; i < 200 && burst_active_o; i++) tick();
        chk("rand_idle", burst_active_o, 0);
        chk("rand_sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
